// File: rtl/phased_array_pwm_gen.sv
// phased_array_pwm_gen: multi-channel phase-offset square-wave drive with
// double-buffered phase/period/duty and a wrap-aligned burst gate.
module phased_array_pwm_gen #(
  parameter int NUM_CH = 49,
  parameter int CNT_W = 11,
  parameter int PERIOD_RST = 1250,
  parameter int DUTY_RST = 625,
  parameter int BURST_W = 8,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]   cfg_phase,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_duty,
  input  logic               cfg_per_we,
  input  logic               commit,
  input  logic [BURST_W-1:0] burst_on,
  input  logic [BURST_W-1:0] burst_off,
  output logic [NUM_CH-1:0]  trans,
  output logic               cycle_start,
  output logic               commit_pend,
  output logic               phase_err
);
  logic [CNT_W-1:0] cnt, per_sh, per_act, duty_sh, duty_act, p;
  logic [CNT_W-1:0] ph_sh [NUM_CH];
  logic [CNT_W-1:0] ph_act [NUM_CH];
  logic [BURST_W-1:0] bcnt;
  logic [NUM_CH-1:0] nxt, bad;
  logic wrap, apply, gate, b_off;
  assign p = per_act < CNT_W'(2) ? CNT_W'(2) : per_act;
  assign wrap = en && cnt == p - 1'b1;
  // A commit lands on the wrap (or at once while stopped) so new values start at cnt=0.
  assign apply = (commit || commit_pend) && (wrap || !en);
  assign gate = burst_on == '0 || !b_off;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W:0] d;
    assign d = cnt >= ph_act[i] ? {1'b0, cnt} - {1'b0, ph_act[i]}
                                : {1'b0, cnt} + {1'b0, p} - {1'b0, ph_act[i]};
    assign bad[i] = ph_act[i] >= p;
    assign nxt[i] = gate && !bad[i] && d < {1'b0, duty_act};
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      for (int j = 0; j < NUM_CH; j++) begin
        ph_sh[j] <= '0;
        ph_act[j] <= '0;
      end
      per_sh <= CNT_W'(PERIOD_RST);
      per_act <= CNT_W'(PERIOD_RST);
      duty_sh <= CNT_W'(DUTY_RST);
      duty_act <= CNT_W'(DUTY_RST);
    end else begin
      if (cfg_we && {1'b0, cfg_ch} < (CH_W+1)'(NUM_CH)) ph_sh[cfg_ch] <= cfg_phase;
      if (cfg_per_we) begin
        per_sh <= cfg_period;
        duty_sh <= cfg_duty;
      end
      if (apply) begin
        for (int j = 0; j < NUM_CH; j++) ph_act[j] <= ph_sh[j];
        per_act <= per_sh;
        duty_act <= duty_sh;
      end
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cnt <= '0;
      trans <= '0;
      cycle_start <= 1'b0;
      commit_pend <= 1'b0;
      phase_err <= 1'b0;
    end else begin
      cnt <= !en || wrap ? '0 : cnt + 1'b1;
      trans <= en ? nxt : '0;
      cycle_start <= en && cnt == '0;
      commit_pend <= !apply && (commit || commit_pend);
      phase_err <= phase_err || |bad;
    end
  // Burst state only moves on wraps, so every driven carrier cycle is complete.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      b_off <= 1'b0;
      bcnt <= '0;
    end else if (!en || burst_on == '0) begin
      b_off <= 1'b0;
      bcnt <= '0;
    end else if (wrap) begin
      if (bcnt + 1'b1 >= (b_off ? burst_off : burst_on)) begin
        bcnt <= '0;
        b_off <= !b_off && burst_off != '0;
      end else
        bcnt <= bcnt + 1'b1;
    end
endmodule
